rom_ctrl: RTL and testbench
===========================

# rom_ctrl

Two-port sequencing controller in front of the instruction/data ROM. Arbitrates round-robin between the instruction-fetch port (1- or 2-byte reads) and the data-load port (1-byte reads). Drives the ROM's one-cycle read/ready protocol and returns assembled data with a one-cycle acknowledge. Sits between the CPU core and `rom`; it is the only master of the ROM.

## Interface
- `size_addr`, 8: ROM address width in bits.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `f_req`  in  1: fetch request; held with `f_addr` and `f_len` stable until `f_ack`.
- `f_addr`  in  size_addr: fetch start byte address.
- `f_len`  in  1: 0 = 1 byte, 1 = 2 bytes (little-endian).
- `f_ack`  out  1: one-cycle pulse; `f_data` valid in the same cycle.
- `f_data`  out  16: fetched bytes; `[7:0]` at `f_addr`, `[15:8]` at `f_addr+1`; upper byte is 0 when `f_len=0`.
- `d_req`  in  1: load request; held with `d_addr` stable until `d_ack`.
- `d_addr`  in  size_addr: load byte address.
- `d_ack`  out  1: one-cycle pulse; `d_data` valid in the same cycle.
- `d_data`  out  8: loaded byte.
- `rom_read`  out  1: ROM read strobe.
- `rom_address`  out  size_addr: ROM address; meaningful only while `rom_read=1`.
- `rom_ready`  in  1: ROM ready; high the cycle after `rom_read`.
- `rom_data`  in  8: ROM output byte; valid while `rom_ready=1`.

## Operation
- FSM states: IDLE, RD0, WT0, RD1, WT1, DONE.
- IDLE: sample `f_req` and `d_req`.
  - Neither high: stay in IDLE.
  - One high: grant it.
  - Both high: grant the port not granted last.
  - On grant: latch port id, address and length (`d` port forced to 1 byte), then go to RD0.
- RD0 / RD1: `rom_read=1`. `rom_address` = latched address (RD0) or latched address + 1 (RD1). Go to WT0 / WT1.
- WT0 / WT1: wait for `rom_ready=1`, then capture `rom_data` into byte 0 / byte 1.
  - WT0 with length 2 goes to RD1; otherwise to DONE.
  - WT1 goes to DONE.
  - `rom_ready=0` stays in the WT state.
- DONE: pulse the granted port's ack for one cycle, drive its data, update the last-grant record, go to IDLE.
- Address increment wraps modulo 2^size_addr; 0xFF + 1 reads address 0x00.
- Requests are sampled only in IDLE. A request still high in the IDLE cycle after ack is a new request.
- A request arriving while busy waits; it is never dropped.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `rom_read`, `f_ack`, `d_ack`, `f_data`, `d_data`, `rom_address` are all 0.
  - Last-grant record is set to "data", so fetch wins the first tie.
  - An in-flight transaction is abandoned with no ack.
- `f_data` / `d_data` hold their last value until the next ack for that port.

## Timing
- Request first seen high in IDLE at cycle N. `rom_read` is high in N+1.
- 1-byte access: `rom_ready` in N+2, ack in N+3.
- 2-byte fetch: second `rom_read` in N+3, `rom_ready` in N+4, ack in N+5.
- Minimum spacing between back-to-back grants is 4 cycles for 1-byte accesses (IDLE, RD0, WT0, DONE).
- Acks are never both high in the same cycle.
- `rom_read` is high for exactly one cycle per byte.

## Structure
- Shared package `rom_ctrl_pkg`:
  - state enumeration (IDLE..DONE);
  - port-id constants `PORT_F=0`, `PORT_D=1`.
- One sub-module `rom_rr_arb2`: 2-input round-robin grant with a last-grant register, updated by a `done` strobe.
- FSM, address counter and byte assembly live in `rom_ctrl`.

## Test plan
- Reset then fetch: `f_req=1`, `f_addr=0x10`, `f_len=0`, ROM[0x10]=0xA5 -> `rom_read` at N+1, `f_ack` at N+3, `f_data=0x00A5`.
- 2-byte fetch with wrap: `f_addr=0xFF`, `f_len=1`, ROM[0xFF]=0x34, ROM[0x00]=0x12 -> `rom_address` 0xFF then 0x00, `f_ack` at N+5, `f_data=0x1234`.
- Tie after reset: `f_req` and `d_req` rise together -> fetch acked first, then load; with both held continuously, grants alternate F, D, F, D.
- Load during fetch: `d_req` rises at N+2 of a 2-byte fetch -> `d_ack` only after `f_ack`, at `f_ack`+4, correct byte returned.
- Reset mid-operation: assert `rst_n=0` in WT1 -> all outputs 0 immediately, no ack. After release, a held `f_req` is restarted from RD0.
- Stalled ROM: hold `rom_ready=0` for 3 extra cycles -> FSM stays in WT0, ack is delayed by 3 cycles, data is correct.

Source files
------------

// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared types and constants for the ROM sequencing controller.
//   state_e  - controller FSM states (idle, read/wait per byte, done)
//   PORT_F   - port id of the instruction-fetch port
//   PORT_D   - port id of the data-load port
package rom_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd0,
        StWt0,
        StRd1,
        StWt1,
        StDone
    } state_e;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rom_ctrl_if.sv
// rom_ctrl_if: bundle of the fetch port, load port and ROM-side signals of rom_ctrl.
//   f_req/f_addr/f_len -> f_ack/f_data : instruction fetch, 1 or 2 bytes
//   d_req/d_addr       -> d_ack/d_data : data load, 1 byte
//   rom_read/rom_address -> rom_ready/rom_data : one-cycle ROM read protocol
// Modports:
//   slave  - the controller view (serves the ports, masters the ROM)
//   master - the environment view (core requesters plus the ROM itself)
interface rom_ctrl_if #(
    parameter int unsigned size_addr = 8
) ();

    logic                 f_req;
    logic [size_addr-1:0] f_addr;
    logic                 f_len;
    logic                 f_ack;
    logic [15:0]          f_data;

    logic                 d_req;
    logic [size_addr-1:0] d_addr;
    logic                 d_ack;
    logic [7:0]           d_data;

    logic                 rom_read;
    logic [size_addr-1:0] rom_address;
    logic                 rom_ready;
    logic [7:0]           rom_data;

    modport slave (
        input  f_req, f_addr, f_len,
        output f_ack, f_data,
        input  d_req, d_addr,
        output d_ack, d_data,
        output rom_read, rom_address,
        input  rom_ready, rom_data
    );

    modport master (
        output f_req, f_addr, f_len,
        input  f_ack, f_data,
        output d_req, d_addr,
        input  d_ack, d_data,
        input  rom_read, rom_address,
        output rom_ready, rom_data
    );

endinterface

// File: rtl/rom_rr_arb2.sv
// rom_rr_arb2: two-input round-robin arbiter.
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_f/req_d - requests from the fetch and load ports
//   done        - strobe: the granted transaction has completed
//   done_port   - port id of the completed transaction
//   gnt_valid   - at least one request present
//   gnt_port    - port id to grant this cycle
// The last-grant record resets to the load port so fetch wins the first tie.
module rom_rr_arb2
    import rom_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_f,
    input  logic req_d,
    input  logic done,
    input  logic done_port,
    output logic gnt_valid,
    output logic gnt_port
);

    logic last_q, last_d;

    always_comb begin
        gnt_valid = req_f | req_d;
        gnt_port  = PORT_F;
        if (req_f && req_d) begin
            gnt_port = (last_q == PORT_F) ? PORT_D : PORT_F;
        end else if (req_d) begin
            gnt_port = PORT_D;
        end
    end

    always_comb begin
        last_d = last_q;
        if (done) begin
            last_d = done_port;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rom_ctrl.sv
// rom_ctrl: sequencing controller in front of the instruction/data ROM.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset; abandons any transaction without ack
//   bus   - rom_ctrl_if.slave: fetch port (1/2-byte, little-endian), load port
//           (1-byte) and the ROM read/ready interface
// One transaction at a time: grant in idle, one read/wait pair per byte, then a
// one-cycle ack to the granted port. Port data registers hold until the next ack.
module rom_ctrl
    import rom_ctrl_pkg::*;
#(
    parameter int unsigned size_addr = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    rom_ctrl_if.slave  bus
);

    state_e               state_q, state_d;
    logic                 port_q, port_d;
    logic [size_addr-1:0] addr_q, addr_d;
    logic                 len_q, len_d;
    logic [7:0]           byte0_q, byte0_d;
    logic [15:0]          f_data_q, f_data_d;
    logic [7:0]           d_data_q, d_data_d;

    logic                 gnt_valid;
    logic                 gnt_port;
    logic                 done;
    logic                 rom_read;
    logic [size_addr-1:0] rom_address;
    logic                 f_ack;
    logic                 d_ack;

    rom_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_f     (bus.f_req),
        .req_d     (bus.d_req),
        .done      (done),
        .done_port (port_q),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        addr_d      = addr_q;
        len_d       = len_q;
        byte0_d     = byte0_q;
        f_data_d    = f_data_q;
        d_data_d    = d_data_q;
        rom_read    = 1'b0;
        rom_address = '0;
        f_ack       = 1'b0;
        d_ack       = 1'b0;
        done        = 1'b0;

        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    port_d  = gnt_port;
                    addr_d  = (gnt_port == PORT_D) ? bus.d_addr : bus.f_addr;
                    // Loads are always single-byte.
                    len_d   = (gnt_port == PORT_F) ? bus.f_len : 1'b0;
                    state_d = StRd0;
                end
            end
            StRd0: begin
                rom_read    = 1'b1;
                rom_address = addr_q;
                state_d     = StWt0;
            end
            StWt0: begin
                if (bus.rom_ready) begin
                    byte0_d = bus.rom_data;
                    if (len_q) begin
                        state_d = StRd1;
                    end else begin
                        // Port data is loaded here so it is already valid in the ack cycle.
                        if (port_q == PORT_F) begin
                            f_data_d = {8'h00, bus.rom_data};
                        end else begin
                            d_data_d = bus.rom_data;
                        end
                        state_d = StDone;
                    end
                end
            end
            StRd1: begin
                rom_read    = 1'b1;
                // Wraps modulo 2^size_addr.
                rom_address = addr_q + size_addr'(1);
                state_d     = StWt1;
            end
            StWt1: begin
                if (bus.rom_ready) begin
                    f_data_d = {bus.rom_data, byte0_q};
                    state_d  = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                f_ack   = (port_q == PORT_F);
                d_ack   = (port_q == PORT_D);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            port_q   <= PORT_F;
            addr_q   <= '0;
            len_q    <= 1'b0;
            byte0_q  <= 8'h00;
            f_data_q <= 16'h0000;
            d_data_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            byte0_q  <= byte0_d;
            f_data_q <= f_data_d;
            d_data_q <= d_data_d;
        end
    end

    assign bus.rom_read    = rom_read;
    assign bus.rom_address = rom_address;
    assign bus.f_ack       = f_ack;
    assign bus.d_ack       = d_ack;
    assign bus.f_data      = f_data_q;
    assign bus.d_data      = d_data_q;

endmodule

// File: tb/tb_rom_ctrl.sv
// tb_rom_ctrl: self-checking bench for rom_ctrl.
// Requester processes drive the two ports from command queues and push the
// expected response (looked up in the bench's ROM image) into per-port
// scoreboards; a monitor pops and compares on every ack. A behavioural ROM
// answers each read strobe with ready one cycle later plus an optional stall.
module tb_rom_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_ctrl_if #(.size_addr(8)) bus ();

    rom_ctrl #(.size_addr(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic       len;
    } cmd_t;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mem [256];
    cmd_t        f_cmd_q [$];
    cmd_t        d_cmd_q [$];
    logic [15:0] exp_f [$];
    logic [7:0]  exp_d [$];
    int          rd_cyc_q [$];
    logic [7:0]  rd_addr_q [$];
    int          ack_port_q [$];
    int          ack_cyc_q [$];
    int          f_ack_cnt = 0;
    int          d_ack_cnt = 0;
    int          last_f_ack_cyc = 0;
    int          last_d_ack_cyc = 0;
    int          f_issue_cyc = 0;
    int          d_issue_cyc = 0;
    int          stall_lo = 0;
    int          stall_hi = 0;
    logic [7:0]  rom_a;
    int          rom_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        errs++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: little-endian bytes from the ROM image, address wraps at 256.
    function automatic logic [15:0] model_f(input logic [7:0] a, input logic len);
        logic [7:0] a1;
        a1 = a + 8'd1;
        return len ? {mem[a1], mem[a]} : {8'h00, mem[a]};
    endfunction

    task automatic push_f(input logic [7:0] a, input logic len);
        cmd_t c;
        c.addr = a;
        c.len  = len;
        f_cmd_q.push_back(c);
    endtask

    task automatic push_d(input logic [7:0] a);
        cmd_t c;
        c.addr = a;
        c.len  = 1'b0;
        d_cmd_q.push_back(c);
    endtask

    task automatic start_f();
        cmd_t c;
        c = f_cmd_q.pop_front();
        bus.f_addr = c.addr;
        bus.f_len  = c.len;
        bus.f_req  = 1'b1;
        exp_f.push_back(model_f(c.addr, c.len));
        f_issue_cyc = cyc;
    endtask

    task automatic start_d();
        cmd_t c;
        c = d_cmd_q.pop_front();
        bus.d_addr = c.addr;
        bus.d_req  = 1'b1;
        exp_d.push_back(mem[c.addr]);
        d_issue_cyc = cyc;
    endtask

    // Fetch requester: holds the request until ack, chains the next command.
    initial begin
        bus.f_req  = 1'b0;
        bus.f_addr = 8'h00;
        bus.f_len  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.f_req && bus.f_ack) begin
                if (f_cmd_q.size() > 0) start_f();
                else bus.f_req = 1'b0;
            end else if (!bus.f_req && f_cmd_q.size() > 0) begin
                start_f();
            end
        end
    end

    // Load requester.
    initial begin
        bus.d_req  = 1'b0;
        bus.d_addr = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.d_req && bus.d_ack) begin
                if (d_cmd_q.size() > 0) start_d();
                else bus.d_req = 1'b0;
            end else if (!bus.d_req && d_cmd_q.size() > 0) begin
                start_d();
            end
        end
    end

    // Behavioural ROM: ready the cycle after the strobe, plus rom_n stall cycles.
    initial begin
        bus.rom_ready = 1'b0;
        bus.rom_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.rom_read) begin
                rom_a = bus.rom_address;
                rom_n = $urandom_range(stall_hi, stall_lo);
                @(posedge clk);
                repeat (rom_n) @(posedge clk);
                #1;
                bus.rom_ready = 1'b1;
                bus.rom_data  = mem[rom_a];
                @(posedge clk);
                #1;
                bus.rom_ready = 1'b0;
                bus.rom_data  = 8'($urandom);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rom_read) begin
                rd_cyc_q.push_back(cyc);
                rd_addr_q.push_back(bus.rom_address);
            end
            if (bus.f_ack || bus.d_ack) begin
                check("ack_exclusive", {31'b0, bus.f_ack & bus.d_ack}, 32'd0);
                ack_cyc_q.push_back(cyc);
            end
            if (bus.f_ack) begin
                f_ack_cnt++;
                last_f_ack_cyc = cyc;
                ack_port_q.push_back(0);
                if (exp_f.size() == 0) fail_now("f_ack_unexpected");
                else check("f_data", {16'b0, bus.f_data}, {16'b0, exp_f.pop_front()});
            end
            if (bus.d_ack) begin
                d_ack_cnt++;
                last_d_ack_cyc = cyc;
                ack_port_q.push_back(1);
                if (exp_d.size() == 0) fail_now("d_ack_unexpected");
                else check("d_data", {24'b0, bus.d_data}, {24'b0, exp_d.pop_front()});
            end
        end
    end

    task automatic wait_quiet(input string name, input int budget);
        int k;
        k = 0;
        while ((f_cmd_q.size() > 0 || d_cmd_q.size() > 0 || bus.f_req || bus.d_req ||
                exp_f.size() > 0 || exp_d.size() > 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) fail_now({name, "_timeout"});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_read"}, {31'b0, bus.rom_read}, 32'd0);
        check({tag, "_rom_address"}, {24'b0, bus.rom_address}, 32'd0);
        check({tag, "_f_ack"}, {31'b0, bus.f_ack}, 32'd0);
        check({tag, "_d_ack"}, {31'b0, bus.d_ack}, 32'd0);
        check({tag, "_f_data"}, {16'b0, bus.f_data}, 32'd0);
        check({tag, "_d_data"}, {24'b0, bus.d_data}, 32'd0);
    endtask

    task automatic begin_test();
        @(posedge clk);
        #2;
        rd_cyc_q.delete();
        rd_addr_q.delete();
        ack_port_q.delete();
        ack_cyc_q.delete();
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] a1;
        int cnt0;
        int rel_cyc;
        int k;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        #1;
        rst_n = 1'b1;

        // Single-byte fetch.
        mem[8'h10] = 8'hA5;
        begin_test();
        push_f(8'h10, 1'b0);
        wait_quiet("fetch1", 50);
        check("fetch1_rd_count", rd_cyc_q.size(), 1);
        if (rd_cyc_q.size() > 0) check("fetch1_rd_cyc", rd_cyc_q[0], f_issue_cyc + 1);
        check("fetch1_ack_cyc", last_f_ack_cyc, f_issue_cyc + 3);
        check("fetch1_f_data", {16'b0, bus.f_data}, 32'h00A5);

        // Two-byte fetch wrapping past 0xFF.
        mem[8'hFF] = 8'h34;
        mem[8'h00] = 8'h12;
        begin_test();
        push_f(8'hFF, 1'b1);
        wait_quiet("fetch2", 50);
        check("fetch2_rd_count", rd_cyc_q.size(), 2);
        if (rd_cyc_q.size() == 2) begin
            check("fetch2_addr0", {24'b0, rd_addr_q[0]}, 32'hFF);
            check("fetch2_addr1", {24'b0, rd_addr_q[1]}, 32'h00);
            check("fetch2_rd1_cyc", rd_cyc_q[1], f_issue_cyc + 3);
        end
        check("fetch2_ack_cyc", last_f_ack_cyc, f_issue_cyc + 5);
        check("fetch2_f_data", {16'b0, bus.f_data}, 32'h1234);

        // Tie after reset, both held: F, D, F, D, F, D.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst2");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        begin_test();
        for (int i = 0; i < 3; i++) begin
            push_f(8'($urandom), 1'b0);
            push_d(8'($urandom));
        end
        wait_quiet("tie", 200);
        check("tie_ack_count", ack_port_q.size(), 6);
        if (ack_port_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check("tie_order", ack_port_q[i], i % 2);
            check("tie_spacing", ack_cyc_q[1] - ack_cyc_q[0], 4);
        end

        // Load arriving two cycles into a two-byte fetch.
        a = 8'($urandom);
        b = 8'($urandom);
        begin_test();
        push_f(a, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        push_d(b);
        wait_quiet("ld_during_f", 100);
        check("ldf_f_ack_cyc", last_f_ack_cyc, f_issue_cyc + 5);
        check("ldf_d_after_f", last_d_ack_cyc, last_f_ack_cyc + 4);
        check("ldf_d_data", {24'b0, bus.d_data}, {24'b0, mem[b]});

        // Stalled ROM: three extra wait cycles.
        stall_lo = 3;
        stall_hi = 3;
        a = 8'($urandom);
        begin_test();
        push_f(a, 1'b0);
        wait_quiet("stall", 100);
        check("stall_rd_count", rd_cyc_q.size(), 1);
        check("stall_ack_cyc", last_f_ack_cyc, f_issue_cyc + 6);
        check("stall_f_data", {16'b0, bus.f_data}, {24'b0, mem[a]});
        stall_lo = 0;
        stall_hi = 0;

        // Reset while waiting for the second fetch byte; request stays held.
        a = 8'($urandom);
        a1 = a + 8'd1;
        begin_test();
        push_f(a, 1'b1);
        k = 0;
        while (!(bus.rom_read && bus.rom_address == a1) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) fail_now("midrst_no_rd1");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cnt0 = f_ack_cnt;
        repeat (3) @(posedge clk);
        #2;
        check("midrst_no_ack", f_ack_cnt, cnt0);
        rd_cyc_q.delete();
        rd_addr_q.delete();
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_quiet("midrst", 100);
        check("midrst_one_ack", f_ack_cnt, cnt0 + 1);
        check("midrst_rd_count", rd_cyc_q.size(), 2);
        if (rd_cyc_q.size() > 0) begin
            check("midrst_restart_addr", {24'b0, rd_addr_q[0]}, {24'b0, a});
            check("midrst_restart_cyc", rd_cyc_q[0], rel_cyc + 1);
        end

        // Randomised traffic with random ROM stalls.
        stall_lo = 0;
        stall_hi = 2;
        begin_test();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1, 0) == 0) push_f(8'($urandom), 1'($urandom));
            else push_d(8'($urandom));
            repeat ($urandom_range(6, 0)) @(posedge clk);
            #2;
        end
        wait_quiet("random", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
